// File: rtl/seq_identifier_n.sv
// Serial bit-pattern detector: compares the newest len_q bits against a loaded reference.
// Optional saturating match counter is built only when SEQ_ID_CNT_EN is defined.
module seq_identifier_n #(
    parameter int SEQ_W = 8,
    parameter int CNT_W = 8,
    localparam int LEN_W = $clog2(SEQ_W) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enb_i,
    input  logic             bit_i,
    input  logic             load_i,
    input  logic [SEQ_W-1:0] ref_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             overlap_i,
    input  logic             cnt_clr_i,
    output logic             flag_o,
    output logic [CNT_W-1:0] match_cnt_o
);

    logic [SEQ_W-1:0] sr_q, sr_d;
    logic [SEQ_W-1:0] ref_q, ref_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             flag_q, flag_d;

    logic [SEQ_W-1:0] sr_shift;
    logic [SEQ_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_inc;
    logic             match;

    // The oldest shift-register bit falls off on every shift and never takes part in a compare.
    logic unused_sr_msb;
    assign unused_sr_msb = sr_q[SEQ_W-1];

    always_comb begin
        sr_d     = sr_q;
        ref_d    = ref_q;
        len_d    = len_q;
        fill_d   = fill_q;
        flag_d   = 1'b0;
        match    = 1'b0;
        sr_shift = {sr_q[SEQ_W-2:0], bit_i};
        fill_inc = (fill_q >= len_q) ? len_q : fill_q + LEN_W'(1);
        // len_q is always 1..SEQ_W, so the shift amount stays within 0..SEQ_W-1.
        len_mask = {SEQ_W{1'b1}} >> (SEQ_W - int'(len_q));

        if (load_i) begin
            ref_d  = ref_i;
            sr_d   = '0;
            fill_d = '0;
            if (len_i == '0) begin
                len_d = LEN_W'(1);
            end else if (len_i > LEN_W'(SEQ_W)) begin
                len_d = LEN_W'(SEQ_W);
            end else begin
                len_d = len_i;
            end
        end else if (enb_i) begin
            sr_d   = sr_shift;
            match  = (((sr_shift ^ ref_q) & len_mask) == '0) && (fill_inc >= len_q);
            fill_d = (match && !overlap_i) ? '0 : fill_inc;
            flag_d = match;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q   <= '0;
            ref_q  <= '0;
            len_q  <= LEN_W'(SEQ_W);
            fill_q <= '0;
            flag_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            ref_q  <= ref_d;
            len_q  <= len_d;
            fill_q <= fill_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

`ifdef SEQ_ID_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a coincident match; the counter sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt_o = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign match_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_seq_identifier_n.sv
// Bench for seq_identifier_n: a bit-history model predicts flag/count every cycle; two
// instances (CNT_W=8 and CNT_W=2) share stimulus. Counter expectations follow SEQ_ID_CNT_EN.
module tb_seq_identifier_n;

    localparam int SEQ_W = 8;
    localparam int LEN_W = $clog2(SEQ_W) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enb = 1'b0;
    logic             bit_in = 1'b0;
    logic             load = 1'b0;
    logic             overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [SEQ_W-1:0] ref_in = '0;
    logic [LEN_W-1:0] len_in = '0;
    logic             flag8, flag2;
    logic [7:0]       cnt8;
    logic [1:0]       cnt2;

    int tests = 0;
    int fails = 0;

    // Model state: consumed bits since the last load/reset/non-overlapping match.
    logic       hist[$];
    logic [7:0] m_ref = '0;
    int         m_len = SEQ_W;
    logic       m_flag = 1'b0;
    int         m_cnt = 0;

    always #5 clk = ~clk;

    seq_identifier_n #(.SEQ_W(SEQ_W), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst), .enb_i(enb), .bit_i(bit_in), .load_i(load),
        .ref_i(ref_in), .len_i(len_in), .overlap_i(overlap), .cnt_clr_i(cnt_clr),
        .flag_o(flag8), .match_cnt_o(cnt8)
    );

    seq_identifier_n #(.SEQ_W(SEQ_W), .CNT_W(2)) dut_w2 (
        .clk_i(clk), .rst_i(rst), .enb_i(enb), .bit_i(bit_in), .load_i(load),
        .ref_i(ref_in), .len_i(len_in), .overlap_i(overlap), .cnt_clr_i(cnt_clr),
        .flag_o(flag2), .match_cnt_o(cnt2)
    );

    function automatic int sat(input int v, input int maxv);
`ifdef SEQ_ID_CNT_EN
        return (v > maxv) ? maxv : v;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_ref  = '0;
        m_len  = SEQ_W;
        m_flag = 1'b0;
        m_cnt  = 0;
    endtask

    // Applies the spec rules for one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic match;
        match = 1'b0;
        if (load) begin
            m_ref = ref_in;
            if (len_in == 0) m_len = 1;
            else if (int'(len_in) > SEQ_W) m_len = SEQ_W;
            else m_len = int'(len_in);
            hist.delete();
        end else if (enb) begin
            hist.push_back(bit_in);
            if (hist.size() > m_len) void'(hist.pop_front());
            if (hist.size() == m_len) begin
                match = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (hist[m_len-1-i] !== m_ref[i]) match = 1'b0;
            end
            if (match && !overlap) hist.delete();
        end
        m_flag = match;
        if (cnt_clr) m_cnt = 0;
        else if (match) m_cnt++;
    endtask

    // Compare process: outputs checked against the model on every falling edge.
    always @(negedge clk) begin
        check("flag8", int'(flag8), int'(m_flag));
        check("flag2", int'(flag2), int'(m_flag));
        check("cnt8", int'(cnt8), sat(m_cnt, 255));
        check("cnt2", int'(cnt2), sat(m_cnt, 3));
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input logic b);
        enb = 1'b1;
        bit_in = b;
        tick();
        enb = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i]);
    endtask

    task automatic do_load(input logic [7:0] r, input logic [LEN_W-1:0] l);
        load = 1'b1;
        ref_in = r;
        len_in = l;
        tick();
        load = 1'b0;
    endtask

    task automatic clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst = 1'b1;
        #1;
        check("reset_flag", int'(flag8), 0);
        check("reset_cnt", int'(cnt8), 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        // Ref 0xFB: bits above len are don't-care, so this behaves as 4'b1011.
        overlap = 1'b1;
        do_load(8'hFB, 4);
        send_bits(8'b1011, 4);
        check("basic_flag", int'(flag8), 1);
        check("basic_cnt", int'(cnt8), sat(1, 255));
        tick();
        check("basic_flag_drop", int'(flag8), 0);

        // 1010 pattern, overlapping then non-overlapping.
        clr();
        do_load(8'h0A, 4);
        send_bits(8'b101010, 6);
        check("ovl1_flag6", int'(flag8), 1);
        check("ovl1_cnt", int'(cnt8), sat(2, 255));
        clr();
        overlap = 1'b0;
        do_load(8'h0A, 4);
        send_bits(8'b101010, 6);
        check("ovl0_flag6", int'(flag8), 0);
        check("ovl0_cnt", int'(cnt8), sat(1, 255));

        // All-zero reference needs four fresh zeros.
        do_load(8'h00, 4);
        send_bits(8'b000, 3);
        check("zero_3bits", int'(flag8), 0);
        send(1'b0);
        check("zero_4bits", int'(flag8), 1);

        // len 0 clamps to a single-bit pattern.
        overlap = 1'b1;
        do_load(8'h01, 0);
        send(1'b1);
        check("len0_one", int'(flag8), 1);
        send(1'b0);
        check("len0_zero", int'(flag8), 0);
        send_bits(8'b11, 2);

        // Oversized len clamps to SEQ_W.
        do_load(8'hA5, 15);
        send_bits(8'hA5, 8);
        check("len_clamp", int'(flag8), 1);

        // Gaps with enb low and bit_in 0 must not disturb the pattern.
        do_load(8'h0B, 4);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pat;
            pat = 4'b1011;
            send(pat[i]);
            repeat (2) tick();
        end

        // load with enb on the same edge discards the bit.
        load = 1'b1; ref_in = 8'h0B; len_in = 4; enb = 1'b1; bit_in = 1'b1;
        tick();
        load = 1'b0; enb = 1'b0; bit_in = 1'b0;
        send_bits(8'b011, 3);
        check("load_priority", int'(flag8), 0);

        // Saturation of the narrow counter, then clear against a coincident match.
        clr();
        do_load(8'h01, 1);
        send_bits(8'b1111, 4);
        check("sat_cnt2", int'(cnt2), sat(4, 3));
        check("sat_cnt8", int'(cnt8), sat(4, 255));
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        check("clr_vs_match_flag", int'(flag8), 1);
        check("clr_vs_match_cnt", int'(cnt8), 0);

        // Asynchronous reset after 3 of 4 matching bits.
        do_load(8'h0B, 4);
        send_bits(8'b101, 3);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_flag", int'(flag8), 0);
        check("async_rst_cnt", int'(cnt8), 0);
        @(negedge clk);
        #1 rst = 1'b0;
        send_bits(8'b1011, 4);
        check("post_rst_noflag", int'(flag8), 0);

        // Short mixed run with overlap toggling and idle cycles.
        do_load(8'h05, 3);
        for (int i = 0; i < 40; i++) begin
            overlap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tick();
            send(1'($urandom_range(0, 1)));
        end

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_identifier_n.md
SEQ_IDENTIFIER_N -- requirements
Module: seq_identifier_n

Interface
REQ-001 SHALL provide parameter: SEQ_W, 8, maximum reference sequence length in bits (2..32).
REQ-002 SHALL provide parameter: CNT_W, 8, match counter width (1..16).
REQ-003 SHALL derive LEN_W = $clog2(SEQ_W)+1 internally.
REQ-004 SHALL provide port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port: rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL provide port: enb_i  input  1  bit-valid; bit_i is consumed only on edges with enb_i=1.
REQ-007 SHALL provide port: bit_i  input  1  serial data bit.
REQ-008 SHALL provide port: load_i  input  1  latch ref_i/len_i into internal registers.
REQ-009 SHALL provide port: ref_i  input  SEQ_W  reference pattern; bit len-1 is the first bit expected.
REQ-010 SHALL provide port: len_i  input  LEN_W  active pattern length.
REQ-011 SHALL provide port: overlap_i  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL provide port: cnt_clr_i  input  1  synchronous clear of match counter.
REQ-013 SHALL provide port: flag_o  output  1  one-cycle match pulse, registered.
REQ-014 SHALL provide port: match_cnt_o  output  CNT_W  number of matches since reset/clear, saturating.

Function
REQ-015 SHALL hold shift register sr[SEQ_W-1:0]; on enb_i edge sr <= {sr[SEQ_W-2:0], bit_i} (newest bit at sr[0]).
REQ-016 SHALL hold fill counter (LEN_W bits) incremented on each consumed bit, saturating at len_q.
REQ-017 SHALL on load_i edge set ref_q <= ref_i, len_q <= len_i clamped: 0 -> 1, >SEQ_W -> SEQ_W; clear sr and fill.
REQ-018 SHALL give load_i priority over enb_i on the same edge: the bit is discarded, flag_o <= 0.
REQ-019 SHALL match when, after the shift, sr[len_q-1:0] == ref_q[len_q-1:0] and fill (after increment) >= len_q.
REQ-020 SHALL set flag_o <= 1 on the edge consuming the completing bit (visible the following cycle), else flag_o <= 0; never high two cycles without two consumed bits.
REQ-021 SHALL, with overlap_i=0, reset fill to 0 on a match so next detection requires len_q fresh bits; with overlap_i=1, fill unchanged.
REQ-022 SHALL sample overlap_i each edge; a change takes effect on the next consumed bit.
REQ-023 SHALL, with enb_i=0 and load_i=0, hold sr, fill, ref_q, len_q; flag_o <= 0.
REQ-024 SHALL increment match counter on every match, saturate at 2^CNT_W-1 (no wrap).
REQ-025 SHALL give cnt_clr_i priority over a simultaneous increment (result 0).
REQ-026 SHALL compare only the low len_q bits; ref_q bits above len_q are don't-care.

Reset
REQ-027 SHALL on rst_i=1, immediately and regardless of clock: flag_o=0, match_cnt_o=0, sr=0, fill=0, ref_q=0, len_q=SEQ_W.
REQ-028 SHALL abandon any partial sequence on reset mid-stream; first post-reset match needs len_q fresh bits.

Configuration
REQ-029 SHALL, with SEQ_ID_CNT_EN defined, implement match counter and cnt_clr_i per REQ-024/025.
REQ-030 SHALL, without SEQ_ID_CNT_EN, tie match_cnt_o to 0, ignore cnt_clr_i, instantiate no counter flops; flag_o behaviour identical.

Verification (SEQ_W=8, CNT_W=8 unless stated)
REQ-031 SHALL cover: load ref=8'h0B len=4 overlap=1, bits 1,0,1,1 -> flag_o=1 one cycle after 4th edge, match_cnt_o=1.
REQ-032 SHALL cover: ref=4'b1010 len=4, bits 1,0,1,0,1,0 -> overlap=1: flags after bits 4 and 6 (cnt=2); overlap=0: flag after bit 4 only (cnt=1).
REQ-033 SHALL cover: load ref=0 len=4, bits 0,0,0 -> no flag; 4th 0 -> flag; len_i=0 loaded -> single 1-bit pattern, ref=1 flags on each 1.
REQ-034 SHALL cover: pattern 1,0,1,1 with enb_i=0 gaps carrying bit_i=0 between bits -> exactly one flag; load_i with enb_i same edge -> bit discarded.
REQ-035 SHALL cover: CNT_W=2, 4 matches -> match_cnt_o stays 3; cnt_clr_i coincident with match -> 0; without SEQ_ID_CNT_EN -> always 0.
REQ-036 SHALL cover: rst_i pulsed asynchronously after 3 of 4 matching bits -> flag_o=0, cnt=0, len_q=8; next 4 bits of old pattern do not flag.
